scan_doubler: RTL and testbench

SCAN_DOUBLER -- requirements
Module: scan_doubler

---
 rtl/scan_doubler.sv | 173 +++++++++++++++++
 tb/tb_scan_doubler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_doubler.sv
// scan_doubler: line doubler for a 15 kHz-style source feeding a 31 kHz display.
// Incoming pixels (one every other clock, h_half=0) are captured into one of two
// line banks. When the input line ends, the completed bank is replayed twice at
// the full clock rate (PASS0, PASS1) while the next line fills the other bank.
//
// Ports:
//   clk          system clock, single domain
//   rst_n        synchronous active-low reset
//   h_half       input pixel phase; a pixel is taken when 0
//   video_valid  input line active
//   r_sig/g_sig/b_sig  input colour (3/3/2 bits)
//   vsync_in_n   input vertical sync, active-low
//   vga_r/g/b    output colour, registered
//   vga_de       output data enable
//   vga_hs_n     output hsync, active-low
//   vga_vs_n     vsync_in_n delayed one clock
//   overflow     sticky flag: an input line had more than H_ACTIVE pixels
module scan_doubler #(
  parameter int unsigned H_ACTIVE = 256,
  parameter int unsigned H_TOTAL  = 384,
  parameter int unsigned HS_START = 280,
  parameter int unsigned HS_LEN   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       h_half,
  input  logic       video_valid,
  input  logic [2:0] r_sig,
  input  logic [2:0] g_sig,
  input  logic [1:0] b_sig,
  input  logic       vsync_in_n,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b,
  output logic       vga_de,
  output logic       vga_hs_n,
  output logic       vga_vs_n,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(H_ACTIVE);
  localparam int unsigned XW = $clog2(H_ACTIVE + 1);
  localparam int unsigned CW = $clog2(H_TOTAL);

  typedef enum logic [1:0] {IDLE, PASS0, PASS1} state_t;

  // Line banks and per-bank pixel counts; intentionally not reset.
  logic [7:0]    mem [2][H_ACTIVE];
  logic [XW-1:0] cnt [2];

  logic          wr_bank;
  logic [XW-1:0] wr_x;
  logic          vv_d;
  logic          line_ready;
  logic          wr_req;
  logic          wr_en;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] h_cnt_nxt;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic          de_c;
  logic          hs_c;
  logic          pix_ok;

  // ---------------------------------------------------------------- write side
  always_comb begin
    line_ready = vv_d & ~video_valid;
    wr_req     = ~h_half & video_valid;
    wr_en      = wr_req && (32'(wr_x) < H_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank  <= 1'b0;
      wr_x     <= '0;
      vv_d     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      vv_d <= video_valid;
      if (line_ready) begin
        wr_bank <= ~wr_bank;
        wr_x    <= '0;
      end else if (wr_en) begin
        wr_x <= wr_x + XW'(1);
      end
      // A pixel arriving with the bank already full is dropped and flagged.
      if (wr_req && !wr_en) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en)      mem[wr_bank][wr_x[AW-1:0]] <= {r_sig, g_sig, b_sig};
    if (rst_n && line_ready) cnt[wr_bank] <= wr_x;
  end

  // ------------------------------------------------------------ read FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      h_cnt   <= '0;
      rd_bank <= 1'b0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_cnt_nxt;
      if (line_ready) rd_bank <= wr_bank;
    end
  end

  // A new completed line restarts replay from any state, truncating the old one.
  always_comb begin
    state_nxt = state;
    h_cnt_nxt = h_cnt;
    if (line_ready) begin
      state_nxt = PASS0;
      h_cnt_nxt = '0;
    end else begin
      case (state)
        PASS0: begin
          if (32'(h_cnt) == H_TOTAL - 1) begin
            state_nxt = PASS1;
            h_cnt_nxt = '0;
          end else begin
            h_cnt_nxt = h_cnt + CW'(1);
          end
        end
        PASS1: begin
          if (32'(h_cnt) == H_TOTAL - 1) begin
            state_nxt = IDLE;
            h_cnt_nxt = '0;
          end else begin
            h_cnt_nxt = h_cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          h_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    rd_addr = h_cnt[AW-1:0];
    de_c    = (state != IDLE) && (32'(h_cnt) < H_ACTIVE);
    hs_c    = (state != IDLE) && (32'(h_cnt) >= HS_START) &&
              (32'(h_cnt) < HS_START + HS_LEN);
    pix_ok  = de_c && (32'(h_cnt) < 32'(cnt[rd_bank]));
  end

  // ------------------------------------------------------------ output stage
  // The buffer read and the de/hs decode share one register stage so colour,
  // enable and sync leave aligned, one clock after h_cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_r    <= '0;
      vga_g    <= '0;
      vga_b    <= '0;
      vga_de   <= 1'b0;
      vga_hs_n <= 1'b1;
      vga_vs_n <= 1'b1;
    end else begin
      vga_vs_n <= vsync_in_n;
      vga_de   <= de_c;
      vga_hs_n <= ~hs_c;
      if (pix_ok) {vga_r, vga_g, vga_b} <= mem[rd_bank][rd_addr];
      else        {vga_r, vga_g, vga_b} <= '0;
    end
  end

endmodule

// File: tb/tb_scan_doubler.sv
// tb_scan_doubler: directed stimulus with a cycle-stamped scoreboard of the
// expected output stream for scan_doubler (default parameters).
module tb_scan_doubler;

  localparam int HA  = 256;
  localparam int HT  = 384;
  localparam int HSS = 280;
  localparam int HSL = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       h_half;
  logic       video_valid;
  logic [2:0] r_sig;
  logic [2:0] g_sig;
  logic [1:0] b_sig;
  logic       vsync_in_n;
  logic [2:0] vga_r;
  logic [2:0] vga_g;
  logic [1:0] vga_b;
  logic       vga_de;
  logic       vga_hs_n;
  logic       vga_vs_n;
  logic       overflow;

  always #5 clk = ~clk;

  scan_doubler #(.H_ACTIVE(HA), .H_TOTAL(HT), .HS_START(HSS), .HS_LEN(HSL)) dut (
    .clk(clk), .rst_n(rst_n), .h_half(h_half), .video_valid(video_valid),
    .r_sig(r_sig), .g_sig(g_sig), .b_sig(b_sig), .vsync_in_n(vsync_in_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_de(vga_de),
    .vga_hs_n(vga_hs_n), .vga_vs_n(vga_vs_n), .overflow(overflow)
  );

  typedef struct {
    int         cyc;
    logic       de;
    logic       hs_n;
    logic [7:0] rgb;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic mon_en   = 1'b0;
  logic exp_vs   = 1'b1;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    exp_vs <= rst_n ? vsync_in_n : 1'b1;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] pv(input int kind, input int i);
    case (kind)
      0:       return 8'(i);
      1:       return 8'(i * 7 + 3);
      2:       return 8'(i * 3);
      3:       return 8'(i) ^ 8'h5A;
      4:       return 8'(i + 100);
      5:       return 8'(i) ^ 8'hA0;
      default: return 8'(i + 1);
    endcase
  endfunction

  // Output monitor: everything not scheduled in the scoreboard must be blank.
  exp_t me;
  always @(negedge clk) begin
    if (mon_en) begin
      me.cyc  = cyc;
      me.de   = 1'b0;
      me.hs_n = 1'b1;
      me.rgb  = 8'h00;
      if (sb.size() > 0 && sb[0].cyc == cyc) me = sb.pop_front();
      chk("de",   8'(vga_de),   8'(me.de));
      chk("hs_n", 8'(vga_hs_n), 8'(me.hs_n));
      chk("rgb",  {vga_r, vga_g, vga_b}, me.rgb);
      chk("vs_n", 8'(vga_vs_n), 8'(exp_vs));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prune(input int lim);
    while (sb.size() > 0 && sb[$].cyc >= lim) void'(sb.pop_back());
  endtask

  // Expected replay of a line ending at cycle t: two passes of H_TOTAL clocks,
  // first pixel two clocks after t; anything scheduled later is superseded.
  task automatic push_line(input int t, input int n, input int kind);
    exp_t e;
    prune(t + 2);
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < HT; k++) begin
        e.cyc  = t + 2 + p * HT + k;
        e.de   = (k < HA);
        e.hs_n = !(k >= HSS && k < HSS + HSL);
        e.rgb  = (k < HA && k < n) ? pv(kind, k) : 8'h00;
        sb.push_back(e);
      end
    end
  endtask

  task automatic send_line(input int n, input int kind, input int blank);
    for (int i = 0; i < 2 * n; i++) begin
      tick();
      video_valid = 1'b1;
      h_half      = i[0];
      {r_sig, g_sig, b_sig} = (i[0] == 1'b0) ? pv(kind, i / 2) : ~pv(kind, i / 2);
      vsync_in_n  = ($urandom_range(0, 7) != 0);
    end
    tick();
    video_valid = 1'b0;
    h_half      = ~h_half;
    vsync_in_n  = ($urandom_range(0, 7) != 0);
    push_line(cyc, n, kind);
    for (int b = 1; b < blank; b++) begin
      tick();
      h_half     = ~h_half;
      vsync_in_n = ($urandom_range(0, 7) != 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; h_half = 1'b0; video_valid = 1'b0;
    r_sig = '0; g_sig = '0; b_sig = '0; vsync_in_n = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    chk("ovf_reset", 8'(overflow), 8'h00);
    rst_n = 1'b1;
    tick();
    tick();

    // Full 256-pixel line: exactly H_ACTIVE does not overflow.
    send_line(256, 0, 772);
    chk("ovf_full_line", 8'(overflow), 8'h00);

    // Short line: tail of each pass is black.
    send_line(100, 1, 772);
    chk("ovf_short_line", 8'(overflow), 8'h00);

    // Long line: first 256 kept, overflow sticks.
    send_line(300, 2, 772);
    chk("ovf_long_line", 8'(overflow), 8'h01);

    // Second line ends while PASS1 is at h_cnt=50 (T2 = T1 + 435).
    send_line(200, 3, 235);
    send_line(100, 4, 772);
    chk("ovf_sticky1", 8'(overflow), 8'h01);

    // Back-to-back lines, one input line = two output lines.
    send_line(256, 5, 256);
    send_line(256, 6, 772);
    chk("ovf_sticky2", 8'(overflow), 8'h01);

    // Reset during PASS0 with vsync asserted.
    send_line(256, 0, 100);
    tick();
    rst_n = 1'b0;
    vsync_in_n = 1'b0;
    prune(cyc + 1);
    tick();
    chk("rst_rgb",  {vga_r, vga_g, vga_b}, 8'h00);
    chk("rst_de",   8'(vga_de),   8'h00);
    chk("rst_hs_n", 8'(vga_hs_n), 8'h01);
    chk("rst_vs_n", 8'(vga_vs_n), 8'h01);
    chk("rst_ovf",  8'(overflow), 8'h00);
    tick();
    rst_n = 1'b1;
    vsync_in_n = 1'b1;

    // Reset in the middle of an input line: the partial line never replays.
    for (int i = 0; i < 40; i++) begin
      tick();
      video_valid = 1'b1;
      h_half = i[0];
      {r_sig, g_sig, b_sig} = pv(1, i);
    end
    tick();
    rst_n = 1'b0;
    video_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) tick();

    // Normal operation after reset.
    send_line(256, 6, 772);
    tick();
    tick();
    chk("sb_drained", 8'(sb.size()), 8'h00);
    chk("ovf_final",  8'(overflow), 8'h00);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
